wb_io_regs: RTL and testbench

Wishbone-style IO register slave that sits directly downstream of the memory commutator's IO port. It accepts the commutator's single-beat IO strobe, address and write data, and returns an acknowledge and read data. Behind the bus it holds an ID word, a scratch register, a GPIO block with an input synchroniser, and a 32-bit timer with compare match and an interrupt output.

---
 rtl/wb_io_regs.sv | 160 ++++++++++++++++
 tb/tb_wb_io_regs.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_io_regs.sv
// Wishbone-style IO register slave: ID, scratch, GPIO with input synchroniser,
// and a 32-bit timer with compare match, auto-clear and a level interrupt.
// Every request (hit or miss) is acknowledged one cycle after acceptance.
module wb_io_regs #(
  parameter logic [15:0] BASE_ADDR = 16'hF000,
  parameter int          GPIO_W    = 8,
  parameter logic [31:0] ID_VALUE  = 32'h5E1E_0001
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              io_stb_i,
  output logic              io_ack_o,
  input  logic              io_we_i,
  input  logic [15:0]       io_addr_i,
  input  logic [31:0]       io_data_i,
  output logic [31:0]       io_data_o,
  input  logic [GPIO_W-1:0] gpio_i,
  output logic [GPIO_W-1:0] gpio_o,
  output logic              irq_o
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ACK = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [31:0]         scratch_q, scratch_d;
  logic [GPIO_W-1:0]   gpio_out_q, gpio_out_d;
  logic [GPIO_W-1:0]   sync1_q, sync2_q;
  logic [31:0]         cnt_q, cnt_d;
  logic [31:0]         cmp_q, cmp_d;
  logic [2:0]          ctrl_q, ctrl_d;
  logic                match_q, match_d;

  logic                accept_s;
  logic                hit_s;
  logic [2:0]          offset_s;
  logic [7:0]          wr_sel_s;
  logic                match_s;
  logic [31:0]         rd_val_s;
  logic                unused_addr_s;

  // Byte-lane bits of the address carry no meaning for word registers.
  assign unused_addr_s = ^io_addr_i[1:0];

  assign accept_s = (state_q == ST_IDLE) && io_stb_i;
  assign hit_s    = (io_addr_i[15:5] == BASE_ADDR[15:5]);
  assign offset_s = io_addr_i[4:2];

  // Compare match is only meaningful while the timer runs.
  assign match_s  = ctrl_q[0] && (cnt_q == cmp_q);

  assign io_ack_o  = (state_q == ST_ACK);
  assign io_data_o = rdata_q;
  assign gpio_o    = gpio_out_q;
  assign irq_o     = match_q & ctrl_q[1];

  // One-hot write strobes; misses and reads produce none.
  always_comb begin
    wr_sel_s = 8'd0;
    if (accept_s && io_we_i && hit_s) begin
      wr_sel_s[offset_s] = 1'b1;
    end else begin
      wr_sel_s = 8'd0;
    end
  end

  // Read mux over pre-edge register values; unused bits are zero.
  always_comb begin
    rd_val_s = 32'd0;
    case (offset_s)
      3'd0: rd_val_s = ID_VALUE;
      3'd1: rd_val_s = scratch_q;
      3'd2: rd_val_s[GPIO_W-1:0] = gpio_out_q;
      3'd3: rd_val_s[GPIO_W-1:0] = sync2_q;
      3'd4: rd_val_s = cnt_q;
      3'd5: rd_val_s = cmp_q;
      3'd6: rd_val_s[2:0] = ctrl_q;
      3'd7: rd_val_s[0] = match_q;
      default: rd_val_s = 32'd0;
    endcase
  end

  // Bus FSM: accept in IDLE, capture read data, acknowledge for one cycle.
  always_comb begin
    state_d = state_q;
    rdata_d = 32'd0;
    case (state_q)
      ST_IDLE: begin
        if (io_stb_i) begin
          state_d = ST_ACK;
          if (hit_s && !io_we_i) begin
            rdata_d = rd_val_s;
          end else begin
            rdata_d = 32'd0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Register next-state: bus writes, timer count and sticky match flag.
  always_comb begin
    scratch_d  = wr_sel_s[1] ? io_data_i : scratch_q;
    gpio_out_d = wr_sel_s[2] ? io_data_i[GPIO_W-1:0] : gpio_out_q;
    cmp_d      = wr_sel_s[5] ? io_data_i : cmp_q;
    ctrl_d     = wr_sel_s[6] ? io_data_i[2:0] : ctrl_q;

    // A bus write wins over auto-clear, which wins over increment.
    if (wr_sel_s[4]) begin
      cnt_d = io_data_i;
    end else if (match_s && ctrl_q[2]) begin
      cnt_d = 32'd0;
    end else if (ctrl_q[0]) begin
      cnt_d = cnt_q + 32'd1;
    end else begin
      cnt_d = cnt_q;
    end

    // A fresh match beats a simultaneous write-1-to-clear.
    if (match_s) begin
      match_d = 1'b1;
    end else if (wr_sel_s[7] && io_data_i[0]) begin
      match_d = 1'b0;
    end else begin
      match_d = match_q;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q    <= ST_IDLE;
      rdata_q    <= 32'd0;
      scratch_q  <= 32'd0;
      gpio_out_q <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      cnt_q      <= 32'd0;
      cmp_q      <= 32'd0;
      ctrl_q     <= 3'd0;
      match_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rdata_q    <= rdata_d;
      scratch_q  <= scratch_d;
      gpio_out_q <= gpio_out_d;
      sync1_q    <= gpio_i;
      sync2_q    <= sync1_q;
      cnt_q      <= cnt_d;
      cmp_q      <= cmp_d;
      ctrl_q     <= ctrl_d;
      match_q    <= match_d;
    end
  end

endmodule

// File: tb/tb_wb_io_regs.sv
// Self-checking bench for wb_io_regs: table-driven bus accesses with a
// read-data scoreboard, plus hand-timed timer, GPIO and reset sequences.
module tb_wb_io_regs;

  logic        clk;
  logic        rst_n;
  logic        io_stb;
  logic        io_ack;
  logic        io_we;
  logic [15:0] io_addr;
  logic [31:0] io_wdata;
  logic [31:0] io_rdata;
  logic [7:0]  gpio_in;
  logic [7:0]  gpio_out;
  logic        irq;

  int n_chk;
  int n_fail;

  typedef struct packed {
    logic        rd;
    logic [15:0] addr;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[25];

  wb_io_regs #(
    .BASE_ADDR(16'hF000),
    .GPIO_W   (8),
    .ID_VALUE (32'h5E1E_0001)
  ) dut (
    .sys_clk  (clk),
    .sys_rst  (rst_n),
    .io_stb_i (io_stb),
    .io_ack_o (io_ack),
    .io_we_i  (io_we),
    .io_addr_i(io_addr),
    .io_data_i(io_wdata),
    .io_data_o(io_rdata),
    .gpio_i   (gpio_in),
    .gpio_o   (gpio_out),
    .irq_o    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: every acknowledge retires the oldest outstanding request.
  always @(negedge clk) begin
    if (io_ack === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_ack", 32'd1, 32'd0);
      end else begin
        sb_t r;
        r = sb_q.pop_front();
        if (r.rd) check($sformatf("rdata@%h", r.addr), io_rdata, r.exp);
      end
    end
  end

  // One bus access; returns 1ns after the edge that ends the ACK cycle.
  task automatic bus(input logic we, input logic [15:0] addr,
                     input logic [31:0] wd, input logic [31:0] exp);
    int n;
    @(negedge clk);
    io_stb   = 1'b1;
    io_we    = we;
    io_addr  = addr;
    io_wdata = wd;
    sb_q.push_back({!we, addr, exp});
    @(posedge clk); #1;
    check("ack_latency", {31'd0, io_ack}, 32'd1);
    n = 0;
    while (io_ack !== 1'b1 && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    io_stb = 1'b0;
    io_we  = 1'b0;
    @(posedge clk); #1;
    check("ack_width", {31'd0, io_ack}, 32'd0);
  endtask

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    io_stb   = 1'b0;
    io_we    = 1'b0;
    io_addr  = 16'd0;
    io_wdata = 32'd0;
    gpio_in  = 8'd0;

    tbl[0]  = '{1'b0, 16'hF000, 32'h0,         32'h5E1E_0001};
    tbl[1]  = '{1'b0, 16'hF004, 32'h0,         32'h0};
    tbl[2]  = '{1'b0, 16'hF008, 32'h0,         32'h0};
    tbl[3]  = '{1'b0, 16'hF00C, 32'h0,         32'h0};
    tbl[4]  = '{1'b0, 16'hF010, 32'h0,         32'h0};
    tbl[5]  = '{1'b0, 16'hF014, 32'h0,         32'h0};
    tbl[6]  = '{1'b0, 16'hF018, 32'h0,         32'h0};
    tbl[7]  = '{1'b0, 16'hF01C, 32'h0,         32'h0};
    tbl[8]  = '{1'b1, 16'hF000, 32'hFFFF_FFFF, 32'h0};
    tbl[9]  = '{1'b0, 16'hF000, 32'h0,         32'h5E1E_0001};
    tbl[10] = '{1'b1, 16'hF004, 32'hA5A5_1234, 32'h0};
    tbl[11] = '{1'b0, 16'hF004, 32'h0,         32'hA5A5_1234};
    tbl[12] = '{1'b1, 16'hE004, 32'h0000_0001, 32'h0};
    tbl[13] = '{1'b0, 16'hE004, 32'h0,         32'h0};
    tbl[14] = '{1'b0, 16'hF004, 32'h0,         32'hA5A5_1234};
    tbl[15] = '{1'b0, 16'hF007, 32'h0,         32'hA5A5_1234};
    tbl[16] = '{1'b1, 16'hF018, 32'hFFFF_FFFF, 32'h0};
    tbl[17] = '{1'b0, 16'hF018, 32'h0,         32'h0000_0007};
    tbl[18] = '{1'b1, 16'hF018, 32'h0,         32'h0};
    tbl[19] = '{1'b1, 16'hF01C, 32'h0000_0001, 32'h0};
    tbl[20] = '{1'b0, 16'hF01C, 32'h0,         32'h0};
    tbl[21] = '{1'b1, 16'hF008, 32'h0000_0FFF, 32'h0};
    tbl[22] = '{1'b0, 16'hF008, 32'h0,         32'h0000_00FF};
    tbl[23] = '{1'b1, 16'hF008, 32'h0000_003C, 32'h0};
    tbl[24] = '{1'b0, 16'hF008, 32'h0,         32'h0000_003C};

    #1;
    check("rst_ack", {31'd0, io_ack}, 32'd0);
    check("rst_data", io_rdata, 32'd0);
    check("rst_gpio", {24'd0, gpio_out}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 25; i++) begin
      bus(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp);
    end
    check("gpio_o", {24'd0, gpio_out}, 32'h3C);

    // GPIO input synchroniser: invisible at the next edge, visible after two.
    gpio_in = 8'h81;
    bus(1'b0, 16'hF00C, 32'h0, 32'h0);
    bus(1'b0, 16'hF00C, 32'h0, 32'h81);

    // Timer with auto-clear: match/irq one edge after cnt==5, then restart.
    bus(1'b1, 16'hF014, 32'd5, 32'h0);
    bus(1'b1, 16'hF010, 32'd0, 32'h0);
    bus(1'b1, 16'hF018, 32'd7, 32'h0);
    for (int k = 2; k <= 6; k++) begin
      @(posedge clk); #1;
      check($sformatf("irq_rise_e%0d", k), {31'd0, irq}, (k == 6) ? 32'd1 : 32'd0);
    end
    bus(1'b0, 16'hF010, 32'h0, 32'd0);
    check("irq_hold", {31'd0, irq}, 32'd1);
    bus(1'b1, 16'hF01C, 32'd1, 32'h0);
    check("irq_w1c", {31'd0, irq}, 32'd0);
    @(posedge clk);
    bus(1'b1, 16'hF01C, 32'd1, 32'h0);
    check("irq_w1c_vs_match", {31'd0, irq}, 32'd1);
    bus(1'b0, 16'hF01C, 32'h0, 32'd1);

    // Wraparound: pre-edge reads of the running counter.
    bus(1'b1, 16'hF018, 32'd0, 32'h0);
    bus(1'b1, 16'hF010, 32'hFFFF_FFFE, 32'h0);
    bus(1'b1, 16'hF018, 32'd1, 32'h0);
    bus(1'b0, 16'hF010, 32'h0, 32'hFFFF_FFFF);
    bus(1'b0, 16'hF010, 32'h0, 32'd1);
    bus(1'b1, 16'hF018, 32'd0, 32'h0);
    bus(1'b1, 16'hF010, 32'hFFFF_FFFE, 32'h0);
    bus(1'b1, 16'hF018, 32'd1, 32'h0);
    @(posedge clk);
    bus(1'b0, 16'hF010, 32'h0, 32'd0);
    // CNT write on an increment edge loads the written value.
    bus(1'b1, 16'hF010, 32'h0000_1000, 32'h0);
    bus(1'b0, 16'hF010, 32'h0, 32'h0000_1001);

    // Reset asserted during ACK of a write.
    gpio_in = 8'd0;
    bus(1'b1, 16'hF018, 32'd2, 32'h0);
    check("irq_pre_rst", {31'd0, irq}, 32'd1);
    @(negedge clk);
    io_stb   = 1'b1;
    io_we    = 1'b1;
    io_addr  = 16'hF004;
    io_wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    check("ack_before_rst", {31'd0, io_ack}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ack_async_drop", {31'd0, io_ack}, 32'd0);
    check("gpio_after_rst", {24'd0, gpio_out}, 32'd0);
    check("irq_after_rst", {31'd0, irq}, 32'd0);
    io_stb = 1'b0;
    io_we  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp);
    end

    check("sb_drained", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
